// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a circular byte FIFO fed by CPU store strobes.
// Frames are sent back-to-back with no idle gap while the FIFO holds data.
module uart_tx #(
    parameter int CLKS_PER_BIT    = 868,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rstd,
    input  logic       we,
    input  logic [7:0] w_data,
    output logic       full,
    output logic       busy,
    output logic       uart
);
    localparam int                       DEPTH      = 1 << FIFO_DEPTH_LOG2;
    localparam logic [15:0]              BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_DEPTH_LOG2:0] COUNT_ZERO = {(FIFO_DEPTH_LOG2 + 1){1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [15:0]                baud_q, baud_d;
    logic [2:0]                 bit_idx_q, bit_idx_d;
    logic [7:0]                 shift_q, shift_d;
    logic                       uart_q, uart_d;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
    logic [7:0]                 mem_q [DEPTH];

    logic push_s;
    logic pop_s;
    logic empty_s;
    logic baud_end_s;

    assign full       = (count_q == COUNT_FULL);
    assign empty_s    = (count_q == COUNT_ZERO);
    assign busy       = (state_q != ST_IDLE) || !empty_s;
    assign uart       = uart_q;
    assign baud_end_s = (baud_q == BAUD_LAST);

    // FIFO pointer and occupancy next-state; a push while full is silently dropped
    always_comb begin
        push_s   = we && !full;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage write; contents need no reset since occupancy gates all reads
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= w_data;
        end
    end

    // Frame sequencer; uart_d is the line level from the next edge onward
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        uart_d    = uart_q;
        pop_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = 16'd0;
                uart_d = 1'b1;
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = ST_START;
                    uart_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    baud_d    = 16'd0;
                    bit_idx_d = 3'd0;
                    uart_d    = shift_q[0];
                    state_d   = ST_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    baud_d    = 16'd0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        uart_d  = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        uart_d = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_end_s) begin
                    baud_d = 16'd0;
                    if (!empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = ST_START;
                        uart_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        uart_d  = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = 16'd0;
                uart_d  = 1'b1;
            end
        endcase
    end

    // State registers; reset truncates any frame and empties the FIFO
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q   <= ST_IDLE;
            baud_q    <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            uart_q    <= 1'b1;
            wr_ptr_q  <= {FIFO_DEPTH_LOG2{1'b0}};
            rd_ptr_q  <= {FIFO_DEPTH_LOG2{1'b0}};
            count_q   <= COUNT_ZERO;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            uart_q    <= uart_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed table, corner sequences and
// random traffic checked every cycle against a frame-level reference model.
module tb_uart_tx;
    localparam int CPB   = 4;
    localparam int LOG2  = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;

    logic       clk;
    logic       rstd;
    logic       we;
    logic [7:0] w_data;
    logic       full;
    logic       busy;
    logic       uart;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(LOG2)) dut (
        .clk(clk), .rstd(rstd), .we(we), .w_data(w_data),
        .full(full), .busy(busy), .uart(uart)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model: queued bytes plus the 10-bit frame being sent and time into it
    logic [7:0] mq[$];
    bit         m_active;
    int         m_el;
    logic [9:0] m_bits;

    typedef struct {
        int   offs;
        logic uart;
        logic busy;
    } vec_t;
    vec_t tbl[11];

    function automatic void model_reset();
        mq.delete();
        m_active = 1'b0;
        m_el     = 0;
        m_bits   = 10'h3FF;
    endfunction

    function automatic void model_step(input logic we_v, input logic [7:0] d);
        int n_pre;
        bit full_pre;
        n_pre    = mq.size();
        full_pre = (n_pre == DEPTH);
        if (m_active) begin
            m_el++;
            if (m_el == FRAME) m_active = 1'b0;
        end
        if (!m_active && n_pre > 0) begin
            m_bits   = {1'b1, mq.pop_front(), 1'b0};
            m_active = 1'b1;
            m_el     = 0;
        end
        if (we_v && !full_pre) mq.push_back(d);
    endfunction

    function automatic logic exp_uart();
        return m_active ? m_bits[m_el / CPB] : 1'b1;
    endfunction

    function automatic logic exp_busy();
        return m_active || (mq.size() != 0);
    endfunction

    function automatic logic exp_full();
        return mq.size() == DEPTH;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cycle(input logic we_v, input logic [7:0] d);
        we     = we_v;
        w_data = d;
        @(posedge clk);
        if (rstd) model_step(we_v, d);
        else      model_reset();
        @(negedge clk);
        we = 1'b0;
        chk("uart", {31'd0, uart}, {31'd0, exp_uart()});
        chk("busy", {31'd0, busy}, {31'd0, exp_busy()});
        chk("full", {31'd0, full}, {31'd0, exp_full()});
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (exp_busy() && n < limit) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        chk("idle_timeout", {31'd0, (n < limit)}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int t;
        int n;
        tbl[0]  = '{0,  1'b1, 1'b1};
        tbl[1]  = '{1,  1'b0, 1'b1};
        tbl[2]  = '{4,  1'b0, 1'b1};
        tbl[3]  = '{5,  1'b1, 1'b1};
        tbl[4]  = '{9,  1'b0, 1'b1};
        tbl[5]  = '{13, 1'b1, 1'b1};
        tbl[6]  = '{33, 1'b0, 1'b1};
        tbl[7]  = '{36, 1'b0, 1'b1};
        tbl[8]  = '{37, 1'b1, 1'b1};
        tbl[9]  = '{40, 1'b1, 1'b1};
        tbl[10] = '{41, 1'b1, 1'b0};

        rstd   = 1'b0;
        we     = 1'b0;
        w_data = 8'h00;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00);
        rstd = 1'b1;

        // Single byte 0x55 against hand-written checkpoints
        cycle(1'b1, 8'h55);
        t = 0;
        for (int i = 0; i < 11; i++) begin
            while (t < tbl[i].offs) begin
                cycle(1'b0, 8'h00);
                t++;
            end
            chk("t026_uart", {31'd0, uart}, {31'd0, tbl[i].uart});
            chk("t026_busy", {31'd0, busy}, {31'd0, tbl[i].busy});
        end

        // Back-to-back frames
        cycle(1'b1, 8'h41);
        cycle(1'b1, 8'h42);
        wait_idle(200);

        // Overflow while a frame is in flight
        cycle(1'b1, 8'hAA);
        cycle(1'b0, 8'h00);
        for (int b = 0; b <= 16; b++) begin
            cycle(1'b1, 8'(b));
            if (b == 15) chk("t028_full", {31'd0, full}, 32'd1);
        end
        chk("t028_full_after_drop", {31'd0, full}, 32'd1);
        wait_idle(1000);

        // Push on the stop-terminal edge with one byte queued
        cycle(1'b1, 8'h11);
        cycle(1'b0, 8'h00);
        cycle(1'b1, 8'h22);
        n = 0;
        while (!(m_active && m_el == FRAME - 1) && n < 60) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        chk("t030_reach", {31'd0, (n < 60)}, 32'd1);
        cycle(1'b1, 8'h33);
        chk("t030_start", {31'd0, uart}, 32'd0);
        chk("t030_busy", {31'd0, busy}, 32'd1);
        wait_idle(200);

        // Random traffic, heavy then light, exercising pointer wrap and overflow
        for (int i = 0; i < 600; i++) cycle(($urandom_range(0, 7) == 0), 8'($urandom));
        for (int i = 0; i < 900; i++) cycle(($urandom_range(0, 59) == 0), 8'($urandom));
        wait_idle(1000);

        // Reset asserted during data bit 3
        cycle(1'b1, 8'h5A);
        cycle(1'b1, 8'h66);
        cycle(1'b1, 8'h77);
        n = 0;
        while (!(m_active && (m_el / CPB) == 4) && n < 60) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        chk("t031_reach", {31'd0, (n < 60)}, 32'd1);
        #2 rstd = 1'b0;
        #1;
        model_reset();
        chk("t031_uart", {31'd0, uart}, 32'd1);
        chk("t031_busy", {31'd0, busy}, 32'd0);
        chk("t031_full", {31'd0, full}, 32'd0);
        @(negedge clk);
        cycle(1'b0, 8'h00);
        rstd = 1'b1;
        for (int i = 0; i < 60; i++) cycle(1'b0, 8'h00);
        chk("t031_quiet", {31'd0, uart}, 32'd1);

        // First push after reset release is accepted
        rstd = 1'b0;
        cycle(1'b0, 8'h00);
        rstd = 1'b1;
        cycle(1'b1, 8'h99);
        chk("t025_busy", {31'd0, busy}, 32'd1);
        cycle(1'b0, 8'h00);
        chk("t025_start", {31'd0, uart}, 32'd0);
        wait_idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
